// File: rtl/rshift_8_seq.sv
// Iterative right-shift sequencer: logical/arithmetic shift by 0..31 using a 1/2/4 mux datapath of up to 7 positions per pass.
// Latency: result valid ceil(amt/7)+1 cycles after accept (1 cycle for amt==0); no early exit on saturation.
// Backpressure: result held in DONE until out_ready; a new request is accepted in IDLE or in DONE on the consuming cycle.
module rshift_8_seq #(
  parameter int WIDTH = 8,
  parameter int AMT_W = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic [AMT_W-1:0] in_amt,
  input  logic             in_arith,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             busy
);

  localparam int LVL = $clog2(WIDTH);
  localparam logic [AMT_W-1:0] STEP_MAX = AMT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t           state_q;
  logic [WIDTH-1:0] data_q;
  logic [AMT_W-1:0] rem_q;
  logic             arith_q;
  logic             out_valid_q;
  logic [WIDTH-1:0] out_data_q;

  logic [AMT_W-1:0] step_d;
  logic [WIDTH-1:0] data_d;
  logic             fill;
  logic             accept;

  assign in_ready  = !rst && ((state_q == IDLE) || ((state_q == DONE) && out_ready));
  assign accept    = in_valid && in_ready;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign busy      = (state_q != IDLE);

  // The sign bit never changes under arithmetic fill, so data_q's MSB is the fill source every pass.
  assign fill = arith_q & data_q[WIDTH-1];

  // Per-pass shift: clamp the remaining amount to one pass, then run it through the 1/2/4 mux levels.
  always_comb begin
    step_d = (rem_q > STEP_MAX) ? STEP_MAX : rem_q;
    data_d = data_q;
    for (int k = 0; k < LVL; k++) begin
      if (step_d[k]) begin
        data_d = (data_d >> (1 << k)) |
                 (fill ? ~({WIDTH{1'b1}} >> (1 << k)) : {WIDTH{1'b0}});
      end
    end
  end

  // Sequencer FSM: accept, iterate passes, then hold the registered result until consumed.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      data_q      <= '0;
      rem_q       <= '0;
      arith_q     <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
    end else begin
      case (state_q)
        SHIFT: begin
          data_q <= data_d;
          rem_q  <= rem_q - step_d;
          if (rem_q == step_d) begin
            state_q     <= DONE;
            out_valid_q <= 1'b1;
            out_data_q  <= data_d;
          end
        end
        IDLE, DONE: begin
          // Consumption first; a same-cycle accept below overrides it.
          if ((state_q == DONE) && out_ready) begin
            state_q     <= IDLE;
            out_valid_q <= 1'b0;
          end
          if (accept) begin
            data_q  <= in_data;
            rem_q   <= in_amt;
            arith_q <= in_arith;
            if (in_amt == '0) begin
              state_q     <= DONE;
              out_valid_q <= 1'b1;
              out_data_q  <= in_data;
            end else begin
              state_q     <= SHIFT;
              out_valid_q <= 1'b0;
            end
          end
        end
        default: begin
          state_q     <= IDLE;
          out_valid_q <= 1'b0;
        end
      endcase
    end
  end

endmodule
